// File: rtl/instr_stream_src.sv
// Instruction stream source: a small program buffer that is filled word by
// word over a valid/ready load port and then served to a core fetch stage.
// Fetches that fall past the loaded program return the filler instruction.
// After DRAIN consecutive out-of-range fetches the block reports completion.
module instr_stream_src #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          DRAIN     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [31:0]              load_instr,
  input  logic                     run_start,
  input  logic [31:0]              PCF,
  output logic [31:0]              InstrF,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     done,
  output logic                     misalign_err
);

  // AW addresses one buffer word; CW also holds the value DEPTH itself.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DRAIN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [DW-1:0]  drain_reg, drain_next;
  logic           misalign_reg, misalign_next;

  // Program storage; contents deliberately survive reset (count gates access).
  logic [31:0]    buffer_mem [DEPTH];

  logic [29:0]    word_idx;
  logic           in_range;
  logic           aligned;
  logic           full;
  logic           wr_en;
  logic           drain_hit;

  // Word index is compared unsigned against a zero-extended count so that
  // large PCF values can never alias onto a low buffer entry.
  assign word_idx  = PCF[31:2];
  assign in_range  = (word_idx < {{(30 - CW){1'b0}}, count_reg});
  assign aligned   = (PCF[1:0] == 2'b00);
  assign full      = (count_reg == CW'(DEPTH));
  assign wr_en     = (state_reg == S_LOAD) && load_valid && !full && !load_start;
  assign drain_hit = (state_reg == S_RUN) && !in_range && (drain_reg == DW'(DRAIN - 1));

  // Buffer write: append at the current fill level; full buffer ignores writes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buffer_mem[count_reg[AW-1:0]] <= load_instr;
    end
  end

  // State and bookkeeping registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      drain_reg    <= '0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      drain_reg    <= drain_next;
      misalign_reg <= misalign_next;
    end
  end

  // Next-state logic: load_start wins from any state, run needs a program.
  always_comb begin
    state_next = state_reg;
    if (load_start) begin
      state_next = S_LOAD;
    end else begin
      case (state_reg)
        S_LOAD: if (run_start && (count_reg != '0)) state_next = S_RUN;
        S_RUN:  if (drain_hit) state_next = S_DONE;
        default: state_next = state_reg;
      endcase
    end
  end

  // Fill level, drain counter and sticky misalignment flag updates.
  always_comb begin
    count_next    = count_reg;
    drain_next    = drain_reg;
    misalign_next = misalign_reg;
    if (load_start) begin
      count_next    = '0;
      drain_next    = '0;
      misalign_next = 1'b0;
    end else begin
      if (wr_en) begin
        count_next = count_reg + CW'(1);
      end
      if (state_reg == S_RUN) begin
        // A branch back into the program restarts the drain window.
        drain_next = in_range ? '0 : drain_reg + DW'(1);
        if (!aligned) begin
          misalign_next = 1'b1;
        end
      end
    end
  end

  // Outputs: fetch data is combinational on PCF so the core sees it same cycle.
  always_comb begin
    load_ready   = (state_reg == S_LOAD) && !full;
    done         = (state_reg == S_DONE);
    misalign_err = misalign_reg;
    count        = count_reg;
    InstrF       = NOP_INSTR;
    if ((state_reg == S_RUN) && aligned && in_range) begin
      InstrF = buffer_mem[PCF[AW+1:2]];
    end
  end

endmodule

// File: tb/tb_instr_stream_src.sv
// Directed bench for instr_stream_src: load/serve, full buffer, drain,
// misalignment, start guards and reset during RUN.
module tb_instr_stream_src;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_instr;
  logic        run_start;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic [4:0]  count;
  logic        done;
  logic        misalign_err;

  int n_cmp = 0;
  int n_err = 0;

  instr_stream_src #(.DEPTH(16), .NOP_INSTR(NOP), .DRAIN(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_instr   (load_instr),
    .run_start    (run_start),
    .PCF          (PCF),
    .InstrF       (InstrF),
    .count        (count),
    .done         (done),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance one edge; inputs are then changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One RUN fetch: present PCF, check the same-cycle instruction, clock it.
  task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp);
    PCF = pc;
    #1;
    check_eq(tag, InstrF, exp);
    tick();
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_instr = '0;
    run_start = 1'b0; PCF = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    // Reset state
    check_eq("rst_count", {27'b0, count}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_ready", {31'b0, load_ready}, 32'd0);
    check_eq("rst_misalign", {31'b0, misalign_err}, 32'd0);
    check_eq("rst_instr", InstrF, NOP);

    // Enter LOAD
    load_start = 1'b1; tick(); load_start = 1'b0;
    check_eq("load_ready", {31'b0, load_ready}, 32'd1);
    // run_start with empty buffer is ignored
    run_start = 1'b1; tick(); run_start = 1'b0;
    check_eq("empty_run_ready", {31'b0, load_ready}, 32'd1);
    check_eq("empty_run_done", {31'b0, done}, 32'd0);

    // Load two words
    load_valid = 1'b1; load_instr = 32'h00700313; tick();
    load_instr = 32'h00300113; tick();
    load_valid = 1'b0;
    check_eq("count2", {27'b0, count}, 32'd2);
    PCF = 32'd0; #1;
    check_eq("load_instr_nop", InstrF, NOP);

    // Run: serve, drain with aliasing PCF and branch back, then DONE
    run_start = 1'b1; tick(); run_start = 1'b0;
    check_eq("run_ready", {31'b0, load_ready}, 32'd0);
    fetch("pc0", 32'd0, 32'h00700313);
    fetch("pc4", 32'd4, 32'h00300113);
    fetch("pc8", 32'd8, NOP);
    fetch("pc40", 32'h40, NOP);
    fetch("pc16", 32'd16, NOP);
    check_eq("drain3_done", {31'b0, done}, 32'd0);
    fetch("pc4_back", 32'd4, 32'h00300113);
    fetch("pc8b", 32'd8, NOP);
    fetch("pc12b", 32'd12, NOP);
    fetch("pc16b", 32'd16, NOP);
    check_eq("drain3b_done", {31'b0, done}, 32'd0);
    fetch("pc20b", 32'd20, NOP);
    check_eq("drain_done", {31'b0, done}, 32'd1);
    run_start = 1'b1; PCF = 32'd0; tick(); run_start = 1'b0;
    check_eq("done_held", {31'b0, done}, 32'd1);
    check_eq("done_instr", InstrF, NOP);

    // Full buffer: 17 back-to-back words
    load_start = 1'b1; tick(); load_start = 1'b0;
    check_eq("reload_count", {27'b0, count}, 32'd0);
    check_eq("reload_done", {31'b0, done}, 32'd0);
    load_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      load_instr = 32'h10000000 + i;
      tick();
      if (i == 15) begin
        check_eq("full_count16", {27'b0, count}, 32'd16);
        check_eq("full_ready", {31'b0, load_ready}, 32'd0);
      end
    end
    load_valid = 1'b0;
    check_eq("full_count17", {27'b0, count}, 32'd16);
    run_start = 1'b1; tick(); run_start = 1'b0;
    fetch("full_w0", 32'd0, 32'h10000000);
    fetch("full_w15", 32'd60, 32'h1000000F);

    // Misalignment
    fetch("mis_pc2", 32'd2, NOP);
    check_eq("mis_set", {31'b0, misalign_err}, 32'd1);
    fetch("mis_pc4", 32'd4, 32'h10000001);
    check_eq("mis_held", {31'b0, misalign_err}, 32'd1);

    // load_start + run_start together
    load_start = 1'b1; run_start = 1'b1; tick();
    load_start = 1'b0; run_start = 1'b0;
    check_eq("both_count", {27'b0, count}, 32'd0);
    check_eq("both_ready", {31'b0, load_ready}, 32'd1);
    check_eq("both_misalign", {31'b0, misalign_err}, 32'd0);

    // Reset mid-RUN overrides load_start/load_valid
    load_valid = 1'b1; load_instr = 32'hDEADBEEF; tick(); load_valid = 1'b0;
    run_start = 1'b1; tick(); run_start = 1'b0;
    fetch("rr_pc0", 32'd0, 32'hDEADBEEF);
    reset = 1'b1; load_start = 1'b1; load_valid = 1'b1; PCF = 32'd0; tick();
    reset = 1'b0; load_start = 1'b0; load_valid = 1'b0;
    #1;
    check_eq("rr_count", {27'b0, count}, 32'd0);
    check_eq("rr_done", {31'b0, done}, 32'd0);
    check_eq("rr_ready", {31'b0, load_ready}, 32'd0);
    check_eq("rr_instr", InstrF, NOP);
    run_start = 1'b1; tick(); run_start = 1'b0;
    check_eq("idle_run_ready", {31'b0, load_ready}, 32'd0);
    check_eq("idle_run_instr", InstrF, NOP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
